// File: rtl/led_sched_pkg.sv
// Shared types and widths for the LED pattern scheduler.
package led_sched_pkg;

    localparam int PATTERN_W = 32;
    localparam int PWM_W     = 8;
    localparam int POS_W     = $clog2(PATTERN_W);

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        CHASE  = 2'd1,
        BOUNCE = 2'd2,
        FADE   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [3:0] mode_onehot(input mode_e m);
        return 4'b0001 << m;
    endfunction

endpackage

// File: rtl/led_pattern_sched_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clocks; clr restarts the count.
module tick_gen #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick = en && (tick_cnt == LAST);

endmodule

// File: rtl/led_pattern_sched.sv
// Sequences PMOD and on-board LEDs through count, chase, bounce and PWM-fade
// modes, each held for DWELL ticks; all outputs are registered.
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV = 2_500_000,
    parameter int DWELL    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            advance,
    output logic [3:0][7:0] pmod,
    output logic [7:0]      led,
    output logic [1:0]      mode
);

    localparam int DWELL_W = $clog2(DWELL);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(PATTERN_W - 1);
    localparam logic [PWM_W-1:0]   DUTY_MAX   = '1;

    logic tick;

    mode_e              mode_q,  mode_d;
    dir_e               dir_q,   dir_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [31:0]        step_q,  step_d;
    logic [POS_W-1:0]   pos_q,   pos_d;
    logic [PWM_W-1:0]   duty_q,  duty_d;
    logic               hb_q,    hb_d;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [PATTERN_W-1:0] pattern;
    logic               do_adv;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (!hold),
        .clr  (advance),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= COUNT;
            dir_q   <= DIR_UP;
            dwell_q <= '0;
            step_q  <= '0;
            pos_q   <= '0;
            duty_q  <= '0;
            hb_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
            pos_q   <= pos_d;
            duty_q  <= duty_d;
            hb_q    <= hb_d;
        end
    end

    // NOTE: every always_comb output is defaulted first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        step_d  = step_q;
        pos_d   = pos_q;
        duty_d  = duty_q;
        hb_d    = tick ? ~hb_q : hb_q;
        do_adv  = advance || (tick && (dwell_q == DWELL_LAST));

        if (do_adv) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            dir_d   = DIR_UP;
            dwell_d = '0;
            step_d  = '0;
            pos_d   = '0;
            duty_d  = '0;
        end else if (tick) begin
            dwell_d = dwell_q + 1'b1;
            unique case (mode_q)
                COUNT: step_d = step_q + 32'd1;
                CHASE: pos_d  = pos_q + 1'b1;
                BOUNCE: begin
                    // Direction flips as an endpoint is reached, so each endpoint shows once.
                    if (dir_q == DIR_UP) begin
                        pos_d = pos_q + 1'b1;
                        if (pos_d == POS_MAX) dir_d = DIR_DOWN;
                    end else begin
                        pos_d = pos_q - 1'b1;
                        if (pos_d == '0) dir_d = DIR_UP;
                    end
                end
                FADE: begin
                    if (dir_q == DIR_UP) begin
                        duty_d = duty_q + 1'b1;
                        if (duty_d == DUTY_MAX) dir_d = DIR_DOWN;
                    end else begin
                        duty_d = duty_q - 1'b1;
                        if (duty_d == '0) dir_d = DIR_UP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pattern = '0;
        unique case (mode_q)
            COUNT:        pattern = step_q;
            CHASE,
            BOUNCE:       pattern = PATTERN_W'(1) << pos_q;
            FADE:         pattern = {PATTERN_W{pwm_cnt < duty_q}};
            default:      pattern = '0;
        endcase
    end

    // PWM counter free-runs; only reset touches it.
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pmod <= '0;
            led  <= 8'h01;
            mode <= COUNT;
        end else begin
            pmod <= pattern;
            led  <= {hb_q, 3'b000, mode_onehot(mode_q)};
            mode <= mode_q;
        end
    end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench: small-DWELL instance for reset/rollover/hold/advance, and a
// long-DWELL instance for chase wrap, bounce endpoints, fade duty and mid-fade reset.
module tb_led_pattern_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, hold_a, adv_a;
    logic [3:0][7:0] pmod_a;
    logic [7:0]      led_a;
    logic [1:0]      mode_a;

    logic            rst_b, hold_b, adv_b;
    logic [3:0][7:0] pmod_b;
    logic [7:0]      led_b;
    logic [1:0]      mode_b;

    led_pattern_sched #(.TICK_DIV(4), .DWELL(8)) dut_a (
        .clk(clk), .rst(rst_a), .hold(hold_a), .advance(adv_a),
        .pmod(pmod_a), .led(led_a), .mode(mode_a)
    );

    led_pattern_sched #(.TICK_DIV(4), .DWELL(600)) dut_b (
        .clk(clk), .rst(rst_b), .hold(hold_b), .advance(adv_b),
        .pmod(pmod_b), .led(led_b), .mode(mode_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Release hold for exactly n ticks of dut_b, then freeze again.
    task automatic run_ticks_b(input int n);
        hold_b = 1'b0;
        cyc(4 * n);
        hold_b = 1'b1;
    endtask

    // With dut_b frozen, count high cycles of one bit over a full PWM period.
    task automatic measure_b(input string tag, input int exp);
        int hi  = 0;
        int bad = 0;
        cyc(1);
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (pmod_b[0][0]) hi++;
            if (pmod_b != 32'h0 && pmod_b != 32'hFFFF_FFFF) bad++;
        end
        check(tag, hi, exp);
        check({tag, "_uniform"}, bad, 0);
    endtask

    initial begin
        rst_a = 1'b1; hold_a = 1'b0; adv_a = 1'b0;
        rst_b = 1'b1; hold_b = 1'b0; adv_b = 1'b0;

        // Reset and first ticks
        cyc(3);
        check("rst_pmod", pmod_a, 32'h0);
        check("rst_led",  {24'h0, led_a}, 32'h01);
        check("rst_mode", {30'h0, mode_a}, 32'h0);
        rst_a = 1'b0;
        cyc(4);
        check("cnt_c4",   pmod_a, 32'h0);
        cyc(1);
        check("cnt_c5",   {24'h0, pmod_a[0]}, 32'h01);
        check("hb_c5",    {24'h0, led_a}, 32'h81);
        cyc(4);
        check("cnt_c9",   pmod_a, 32'h2);

        // Dwell rollover into CHASE
        cyc(23);
        check("dw_c32_mode", {30'h0, mode_a}, 32'h0);
        check("dw_c32_pmod", pmod_a, 32'h7);
        cyc(1);
        check("dw_c33_mode", {30'h0, mode_a}, 32'h1);
        check("dw_c33_led",  {24'h0, led_a}, 32'h02);
        check("dw_c33_pmod", pmod_a, 32'h1);
        cyc(4);
        check("chase_p1",    {24'h0, pmod_a[0]}, 32'h02);
        check("chase_led",   {24'h0, led_a}, 32'h82);

        // Hold in COUNT, then advance while held
        rst_a = 1'b1;
        cyc(1);
        rst_a = 1'b0;
        cyc(6);
        hold_a = 1'b1;
        cyc(50);
        check("hold_pmod", pmod_a, 32'h1);
        check("hold_mode", {30'h0, mode_a}, 32'h0);
        check("hold_led",  {24'h0, led_a}, 32'h81);
        adv_a = 1'b1;
        cyc(1);
        adv_a = 1'b0;
        cyc(1);
        check("hadv_mode", {30'h0, mode_a}, 32'h1);
        check("hadv_pmod", pmod_a, 32'h1);
        check("hadv_led",  {24'h0, led_a}, 32'h82);
        cyc(10);
        check("hadv_stay", {30'h0, mode_a}, 32'h1);

        // Advance on the dwell-expiry edge
        hold_a = 1'b0;
        cyc(31);
        adv_a = 1'b1;
        cyc(1);
        adv_a = 1'b0;
        cyc(1);
        check("coinc_mode", {30'h0, mode_a}, 32'h2);
        check("coinc_pmod", pmod_a, 32'h1);
        cyc(4);
        check("coinc_next", pmod_a, 32'h2);
        check("coinc_keep", {30'h0, mode_a}, 32'h2);

        // Chase wrap on the long-dwell instance
        cyc(1);
        rst_b = 1'b0;
        adv_b = 1'b1;
        cyc(1);
        adv_b = 1'b0;
        check("b_mode_chase", {30'h0, mode_b}, 32'h0);
        cyc(125);
        check("wrap_p31",  {24'h0, pmod_b[3]}, 32'h80);
        check("wrap_full", pmod_b, 32'h8000_0000);
        cyc(4);
        check("wrap_p0",   pmod_b, 32'h1);

        // Bounce endpoints
        adv_b = 1'b1;
        cyc(1);
        adv_b = 1'b0;
        cyc(121);
        check("bnc_30a", {24'h0, pmod_b[3]}, 32'h40);
        cyc(4);
        check("bnc_31",  {24'h0, pmod_b[3]}, 32'h80);
        cyc(4);
        check("bnc_30b", {24'h0, pmod_b[3]}, 32'h40);
        check("bnc_mode", {30'h0, mode_b}, 32'h2);
        cyc(116);
        check("bnc_1a",  pmod_b, 32'h2);
        cyc(4);
        check("bnc_0",   pmod_b, 32'h1);
        cyc(4);
        check("bnc_1b",  pmod_b, 32'h2);

        // Fade: enter frozen at duty 0, then probe duty by high-cycle count
        hold_b = 1'b1;
        adv_b  = 1'b1;
        cyc(1);
        adv_b  = 1'b0;
        measure_b("fade_d0", 0);
        check("fade_mode", {30'h0, mode_b}, 32'h3);
        run_ticks_b(64);
        measure_b("fade_d64", 64);
        run_ticks_b(190);
        measure_b("fade_d254", 254);
        run_ticks_b(1);
        measure_b("fade_d255", 255);
        run_ticks_b(1);
        measure_b("fade_d254dn", 254);
        run_ticks_b(1);
        measure_b("fade_d253dn", 253);
        run_ticks_b(216);
        measure_b("fade_d37", 37);

        // Reset mid-fade wins over advance and hold
        rst_b  = 1'b1;
        adv_b  = 1'b1;
        cyc(1);
        check("mrst_mode", {30'h0, mode_b}, 32'h0);
        check("mrst_pmod", pmod_b, 32'h0);
        check("mrst_led",  {24'h0, led_b}, 32'h01);
        rst_b  = 1'b0;
        adv_b  = 1'b0;
        hold_b = 1'b0;
        cyc(4);
        check("mrst_c4", pmod_b, 32'h0);
        cyc(1);
        check("mrst_c5", pmod_b, 32'h1);
        check("mrst_c5_mode", {30'h0, mode_b}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
